// File: rtl/led_breath_sched.sv
// LED breathing scheduler: ramps duty1 up, holds, ramps down, holds, and repeats
// while en is high; duty2 mirrors or complements duty1 for a second PWM channel.
module led_breath_sched #(
   parameter int unsigned TICK_DIV   = 195312,
   parameter int unsigned HOLD_TICKS = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] step,
   input  logic       mode,
   output logic [7:0] duty1,
   output logic [7:0] duty2,
   output logic       busy,
   output logic       cyc_done
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {
      IDLE,
      UP,
      HOLD_HI,
      DOWN,
      HOLD_LO
   } state_t;

   state_t        state;
   logic [PW-1:0] pre_cnt;
   logic [7:0]    hold_cnt;
   logic [3:0]    step_lat;

   logic          tick;
   logic [8:0]    up_sum;
   logic          up_sat;
   logic          dn_sat;
   logic [7:0]    dn_diff;
   logic          hold_last;
   logic [3:0]    step_in;

   // Channel 2 is either a copy of channel 1 or its complement.
   function automatic logic [7:0] chan2(input logic [7:0] d, input logic m);
      return m ? d : (8'd255 - d);
   endfunction

   assign tick      = (state != IDLE) && (pre_cnt == PW'(TICK_DIV - 1));
   assign up_sum    = {1'b0, duty1} + {5'd0, step_lat};
   assign up_sat    = (up_sum >= 9'd255);
   assign dn_sat    = (duty1 <= {4'd0, step_lat});
   assign dn_diff   = duty1 - {4'd0, step_lat};
   assign hold_last = (hold_cnt == 8'(HOLD_TICKS - 1));
   assign step_in   = (step == 4'd0) ? 4'd1 : step;

   // NOTE: state is updated with non-blocking assignments so every branch reads
   // the pre-edge values of duty1, pre_cnt and hold_cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pre_cnt  <= '0;
         hold_cnt <= '0;
         step_lat <= 4'd1;
         duty1    <= 8'd0;
         duty2    <= chan2(8'd0, mode);
         busy     <= 1'b0;
         cyc_done <= 1'b0;
      end else begin
         // NOTE: defaults first; the case below overrides them only where
         // duty1 moves or the cycle ends, so duty2 always tracks mode.
         cyc_done <= 1'b0;
         duty2    <= chan2(duty1, mode);
         if (state != IDLE) begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
         end

         case (state)
            IDLE: begin
               if (en) begin
                  state    <= UP;
                  busy     <= 1'b1;
                  pre_cnt  <= '0;
                  hold_cnt <= '0;
                  step_lat <= step_in;
               end
            end

            UP: begin
               if (tick) begin
                  if (up_sat) begin
                     duty1 <= 8'd255;
                     duty2 <= chan2(8'd255, mode);
                     state <= HOLD_HI;
                  end else begin
                     duty1 <= up_sum[7:0];
                     duty2 <= chan2(up_sum[7:0], mode);
                  end
               end
            end

            HOLD_HI: begin
               if (tick) begin
                  if (hold_last) begin
                     hold_cnt <= '0;
                     state    <= DOWN;
                  end else begin
                     hold_cnt <= hold_cnt + 8'd1;
                  end
               end
            end

            DOWN: begin
               if (tick) begin
                  if (dn_sat) begin
                     duty1 <= 8'd0;
                     duty2 <= chan2(8'd0, mode);
                     state <= HOLD_LO;
                  end else begin
                     duty1 <= dn_diff;
                     duty2 <= chan2(dn_diff, mode);
                  end
               end
            end

            HOLD_LO: begin
               if (tick) begin
                  if (hold_last) begin
                     hold_cnt <= '0;
                     cyc_done <= 1'b1;
                     // The prescaler keeps its phase across back-to-back cycles.
                     if (en) begin
                        state    <= UP;
                        step_lat <= step_in;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + 8'd1;
                  end
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_breath_sched.sv
// Scoreboard bench for led_breath_sched: a timeline model predicts every output
// per clock edge; a monitor pops and compares after each rising edge.
module tb_led_breath_sched;

   localparam int TD   = 4;
   localparam int HOLD = 2;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] step;
   logic       mode;
   logic [7:0] duty1;
   logic [7:0] duty2;
   logic       busy;
   logic       cyc_done;

   led_breath_sched #(.TICK_DIV(TD), .HOLD_TICKS(HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .step     (step),
      .mode     (mode),
      .duty1    (duty1),
      .duty2    (duty2),
      .busy     (busy),
      .cyc_done (cyc_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int d1;
      int d2;
      int busy;
      int done;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   edge_no = 0;

   // Reference model: a breathing cycle is a precomputed list of per-tick duty values.
   bit   m_active = 0;
   int   m_k = 0;
   int   m_j = 0;
   int   m_duty = 0;
   int   m_up_len = 0;
   int   m_seq[$];

   task automatic check(input string name, input int act, input int exp, input int cyc);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic build_seq(input int s);
      int se;
      int v;
      se = (s == 0) ? 1 : s;
      m_seq.delete();
      v = 0;
      do begin
         v = (v + se >= 255) ? 255 : v + se;
         m_seq.push_back(v);
      end while (v < 255);
      m_up_len = m_seq.size();
      for (int i = 0; i < HOLD; i++) m_seq.push_back(255);
      do begin
         v = (v <= se) ? 0 : v - se;
         m_seq.push_back(v);
      end while (v > 0);
      for (int i = 0; i < HOLD; i++) m_seq.push_back(0);
   endtask

   task automatic model_edge(input bit r, input bit e, input int s, input bit m);
      exp_t x;
      int   done;
      done = 0;
      if (r) begin
         m_active = 0;
         m_duty   = 0;
         m_k      = 0;
         m_j      = 0;
      end else if (!m_active) begin
         if (e) begin
            m_active = 1;
            m_k      = 0;
            m_j      = 0;
            build_seq(s);
         end
      end else begin
         m_k++;
         if (m_k % TD == 0) begin
            m_j    = m_k / TD;
            m_duty = m_seq[m_j-1];
            if (m_j == m_seq.size()) begin
               done = 1;
               if (e) begin
                  m_k = 0;
                  m_j = 0;
                  build_seq(s);
               end else begin
                  m_active = 0;
               end
            end
         end
      end
      x.d1   = m_duty;
      x.d2   = m ? m_duty : 255 - m_duty;
      x.busy = m_active ? 1 : 0;
      x.done = done;
      x.cyc  = edge_no;
      exp_q.push_back(x);
   endtask

   task automatic drive(input bit r, input bit e, input int s, input bit m);
      @(negedge clk);
      rst  = r;
      en   = e;
      step = s[3:0];
      mode = m;
      edge_no++;
      model_edge(r, e, s, m);
   endtask

   task automatic budget_fail(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s actual=timeout expected=condition_reached", name);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            check("duty1", int'(duty1), x.d1, x.cyc);
            check("duty2", int'(duty2), x.d2, x.cyc);
            check("busy", int'(busy), x.busy, x.cyc);
            check("cyc_done", int'(cyc_done), x.done, x.cyc);
         end
      end
   end

   initial begin : driver
      int  n;
      bit  r_en;
      int  r_step;
      bit  r_mode;
      rst  = 1'b1;
      en   = 1'b0;
      step = 4'd0;
      mode = 1'b0;

      // Reset then idle with en low.
      repeat (2) drive(1, 0, 0, 0);
      repeat (20) drive(0, 0, 0, 0);

      // Step 8, a full cycle and the start of the next.
      repeat (300) drive(0, 1, 8, 0);

      // Step 0 behaves as 1: one full 2056-clock cycle.
      drive(1, 0, 0, 0);
      repeat (2060) drive(0, 1, 0, 0);

      // Drop en while rising through 128: graceful stop to IDLE.
      n = 0;
      while (!(m_active && m_j < m_up_len && m_duty == 128) && n < 3000) begin
         drive(0, 1, 0, 0);
         n++;
      end
      if (n >= 3000) budget_fail("reach_duty128");
      n = 0;
      while (m_active && n < 3000) begin
         drive(0, 0, 5, 0);
         n++;
      end
      if (n >= 3000) budget_fail("graceful_stop");
      repeat (20) drive(0, 0, 0, 0);

      // Toggle mode while duty1 is 40.
      n = 0;
      while (!(m_active && m_duty == 40) && n < 500) begin
         drive(0, 1, 8, 0);
         n++;
      end
      if (n >= 500) budget_fail("reach_duty40");
      repeat (30) drive(0, 1, 8, 1);

      // Reset for one cycle during HOLD_HI, en kept high.
      n = 0;
      while (!(m_active && m_j >= m_up_len && m_j < m_up_len + HOLD) && n < 500) begin
         drive(0, 1, 8, 1);
         n++;
      end
      if (n >= 500) budget_fail("reach_hold_hi");
      drive(1, 1, 8, 1);
      repeat (100) drive(0, 1, 8, 0);

      // Random phase: sparse changes of en, step, mode and rare resets.
      r_en   = 1;
      r_step = 3;
      r_mode = 0;
      repeat (6000) begin
         if ($urandom_range(0, 299) == 0) r_en = ~r_en;
         if ($urandom_range(0, 39) == 0) r_step = int'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) r_mode = ~r_mode;
         drive(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0, r_en, r_step, r_mode);
      end

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) budget_fail("scoreboard_drain");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
